// File: rtl/lcd_pkg.sv
// lcd_pkg: default HD44780 timing (50 MHz cycles), command codes and FSM encodings
// shared by the byte transmitter and the top-level sequencer.
package lcd_pkg;
    localparam int LCD_T_PWRUP = 750000;
    localparam int LCD_T_INIT1 = 205000;
    localparam int LCD_T_INIT2 = 5000;
    localparam int LCD_T_E     = 12;
    localparam int LCD_T_NIB   = 50;
    localparam int LCD_T_CMD   = 2000;
    localparam int LCD_T_CLR   = 82000;

    localparam logic [7:0] FUNC_SET = 8'h28;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] ADDR_L1  = 8'h80;
    localparam logic [7:0] ADDR_L2  = 8'hC0;

    typedef enum logic [2:0] {
        ST_PWRUP, ST_INIT_NIB, ST_INIT_CMD, ST_SET_ADDR, ST_WRITE_CHAR
    } lcd_state_e;

    typedef enum logic [2:0] {
        TX_IDLE, TX_SUH, TX_EH, TX_GAP, TX_SUL, TX_EL, TX_WAIT
    } tx_state_e;

    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        return step == 2'd0 ? FUNC_SET : step == 2'd1 ? ENTRY : step == 2'd2 ? DISP_ON : CLEAR;
    endfunction
endpackage

// File: rtl/lcd_byte_tx.sv
// lcd_byte_tx: sends one byte (or a lone low nibble) over the 4-bit HD44780 bus,
// owning E pulse timing and the post-byte wait; the byte is latched on start.
module lcd_byte_tx
    import lcd_pkg::*;
#(
    parameter int T_E   = LCD_T_E,
    parameter int T_NIB = LCD_T_NIB
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  tx_byte,
    input  logic        rs,
    input  logic        nibble_only,
    input  logic [19:0] post_wait,
    output logic        busy,
    output logic        done,
    output logic        lcd_rs,
    output logic        lcd_e,
    output logic [3:0]  lcd_d
);
    tx_state_e   st_q, st_d;
    logic [19:0] cnt_q, cnt_d, wait_q, wait_d;
    logic [3:0]  nib_q, nib_d, lo_q, lo_d;
    logic        rs_q, rs_d, e_q, e_d, done_q, done_d, nib_only_q, nib_only_d;
    logic        take, last;

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q       <= TX_IDLE;
            cnt_q      <= '0;
            wait_q     <= '0;
            nib_q      <= '0;
            lo_q       <= '0;
            rs_q       <= 1'b0;
            e_q        <= 1'b0;
            done_q     <= 1'b0;
            nib_only_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            nib_q      <= nib_d;
            lo_q       <= lo_d;
            rs_q       <= rs_d;
            e_q        <= e_d;
            done_q     <= done_d;
            nib_only_q <= nib_only_d;
        end
    end

    always_comb begin
        last = (st_q == TX_EH || st_q == TX_EL) ? cnt_q == 20'(T_E - 1) :
               st_q == TX_GAP                   ? cnt_q == 20'(T_NIB - 1) :
               st_q == TX_WAIT                  ? cnt_q + 20'd1 >= wait_q : 1'b1;
        st_d = st_q;
        case (st_q)
            TX_IDLE: if (start) st_d = TX_SUH;
            TX_SUH:  st_d = TX_EH;
            TX_EH:   if (last) st_d = nib_only_q ? TX_WAIT : TX_GAP;
            TX_GAP:  if (last) st_d = TX_SUL;
            TX_SUL:  st_d = TX_EL;
            TX_EL:   if (last) st_d = TX_WAIT;
            TX_WAIT: if (last) st_d = TX_IDLE;
            default: st_d = TX_IDLE;
        endcase
    end

    always_comb begin
        take       = st_q == TX_IDLE && start;
        cnt_d      = st_d != st_q ? '0 : cnt_q + 20'd1;
        nib_d      = take ? (nibble_only ? tx_byte[3:0] : tx_byte[7:4]) :
                     (st_q == TX_GAP && last) ? lo_q : nib_q;
        lo_d       = take ? tx_byte[3:0] : lo_q;
        rs_d       = take ? rs : rs_q;
        wait_d     = take ? post_wait : wait_q;
        nib_only_d = take ? nibble_only : nib_only_q;
        // E follows the next state so its high time equals the E state dwell exactly
        e_d        = st_d == TX_EH || st_d == TX_EL;
        done_d     = st_q == TX_WAIT && last;
    end

    assign busy   = st_q != TX_IDLE;
    assign done   = done_q;
    assign lcd_rs = rs_q;
    assign lcd_e  = e_q;
    assign lcd_d  = nib_q;
endmodule

// File: rtl/lcd_hd44780_drv.sv
// lcd_hd44780_drv: HD44780 2x16 init + continuous refresh from the chars bus.
// Define LCD_FRAME_SNAPSHOT_EN to write each frame from a shadow copy taken at SET_ADDR(L1).
module lcd_hd44780_drv
    import lcd_pkg::*;
#(
    parameter int T_PWRUP = LCD_T_PWRUP,
    parameter int T_INIT1 = LCD_T_INIT1,
    parameter int T_INIT2 = LCD_T_INIT2,
    parameter int T_E     = LCD_T_E,
    parameter int T_NIB   = LCD_T_NIB,
    parameter int T_CMD   = LCD_T_CMD,
    parameter int T_CLR   = LCD_T_CLR
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] chars,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_e,
    output logic         lcd_4,
    output logic         lcd_5,
    output logic         lcd_6,
    output logic         lcd_7,
    output logic         ready,
    output logic         frame_done
);
    lcd_state_e   st_q, st_d;
    logic [19:0]  cnt_q, cnt_d, post_wait;
    logic [1:0]   step_q, step_d;
    logic [4:0]   idx_q, idx_d;
    logic         pend_q, pend_d, ready_q, ready_d, fdone_q, fdone_d;
    logic         start, adv, tx_busy, tx_done, tx_rs, nib_only;
    logic [7:0]   tx_byte, chr;
    logic [3:0]   lcd_d;
    logic [255:0] src;

`ifdef LCD_FRAME_SNAPSHOT_EN
    logic [255:0] snap_q, snap_d;
    always_comb snap_d = (st_q == ST_SET_ADDR && !pend_q && !idx_q[4]) ? chars : snap_q;
    always_ff @(posedge clk) snap_q <= reset ? '0 : snap_d;
    assign src = snap_q;
`else
    assign src = chars;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q    <= ST_PWRUP;
            cnt_q   <= '0;
            step_q  <= '0;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            ready_q <= 1'b0;
            fdone_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            ready_q <= ready_d;
            fdone_q <= fdone_d;
        end
    end

    assign start = st_q != ST_PWRUP && !pend_q && !tx_busy;
    assign adv   = pend_q && tx_done;

    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_PWRUP:      if (cnt_q == 20'(T_PWRUP - 1)) st_d = ST_INIT_NIB;
            ST_INIT_NIB:   if (adv && step_q == 2'd3) st_d = ST_INIT_CMD;
            ST_INIT_CMD:   if (adv && step_q == 2'd3) st_d = ST_SET_ADDR;
            ST_SET_ADDR:   if (adv) st_d = ST_WRITE_CHAR;
            ST_WRITE_CHAR: if (adv && idx_q[3:0] == 4'hF) st_d = ST_SET_ADDR;
            default:       st_d = ST_PWRUP;
        endcase
    end

    always_comb begin
        cnt_d     = st_q == ST_PWRUP ? cnt_q + 20'd1 : '0;
        step_d    = st_d != st_q ? 2'd0 : adv ? step_q + 2'd1 : step_q;
        idx_d     = (st_q == ST_WRITE_CHAR && adv) ? idx_q + 5'd1 : idx_q;
        pend_d    = start ? 1'b1 : adv ? 1'b0 : pend_q;
        ready_d   = ready_q | (st_q == ST_INIT_CMD && st_d == ST_SET_ADDR);
        fdone_d   = st_q == ST_WRITE_CHAR && adv && idx_q == 5'd31;
        // {~idx, 3'b0} == 8*(31-idx): column 0 of line 1 lives in the top byte
        chr       = src[{~idx_q, 3'b000} +: 8];
        tx_byte   = st_q == ST_INIT_NIB ? (step_q == 2'd3 ? 8'h02 : 8'h03) :
                    st_q == ST_INIT_CMD ? init_cmd(step_q) :
                    st_q == ST_SET_ADDR ? (idx_q[4] ? ADDR_L2 : ADDR_L1) : chr;
        tx_rs     = st_q == ST_WRITE_CHAR;
        nib_only  = st_q == ST_INIT_NIB;
        post_wait = st_q == ST_INIT_NIB ? (step_q == 2'd0 ? 20'(T_INIT1) :
                                           step_q == 2'd1 ? 20'(T_INIT2) : 20'(T_CMD)) :
                    (st_q == ST_INIT_CMD && step_q == 2'd3) ? 20'(T_CLR) : 20'(T_CMD);
    end

    lcd_byte_tx #(.T_E(T_E), .T_NIB(T_NIB)) u_tx (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .tx_byte     (tx_byte),
        .rs          (tx_rs),
        .nibble_only (nib_only),
        .post_wait   (post_wait),
        .busy        (tx_busy),
        .done        (tx_done),
        .lcd_rs      (lcd_rs),
        .lcd_e       (lcd_e),
        .lcd_d       (lcd_d)
    );

    assign {lcd_7, lcd_6, lcd_5, lcd_4} = lcd_d;
    assign lcd_rw     = 1'b0;
    assign ready      = ready_q;
    assign frame_done = fdone_q;
endmodule
